// File: rtl/multi_cycle_pkg.sv
// multi_cycle_pkg: shared encodings for the multi-cycle datapath.
// Sequencer states, operand selects, extend modes, ALU ops.
package multi_cycle_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } mc_state_t;

  // reg_src bit positions
  localparam int RS_PC_A = 0;
  localparam int RS_RD_B = 1;

  // imm_src extend modes
  localparam logic [1:0] IMM_ZX8  = 2'b00;
  localparam logic [1:0] IMM_ZX12 = 2'b01;
  localparam logic [1:0] IMM_BR24 = 2'b10;

  // alu_control ops
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_ORR = 4'h3;
  localparam logic [3:0] ALU_EOR = 4'h4;
  localparam logic [3:0] ALU_MOV = 4'h5;

  localparam int PC_INC = 4;

endpackage

// File: rtl/mc_register_file.sv
// mc_register_file: 2 async read ports, 1 sync write port.
// The PC alias index reads the r15 input instead of storage.
module mc_register_file
  import multi_cycle_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic [WIDTH-1:0]      r15,
  output logic [WIDTH-1:0]      rd1,
  output logic [WIDTH-1:0]      rd2
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] PC_IDX =
    REG_ADDR_W'(PC_REG);

  logic [WIDTH-1:0] regs [NREG];

  // storage: cleared by reset, written on we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == PC_IDX) ? r15 : regs[ra1];
  assign rd2 = (ra2 == PC_IDX) ? r15 : regs[ra2];

endmodule

// File: rtl/multi_cycle_data_path.sv
// multi_cycle_data_path: 3-5 cycle datapath over one shared
// memory port, sequenced by an inline FETCH..WRITEBACK FSM.
module multi_cycle_data_path
  import multi_cycle_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               REG_ADDR_W = 4,
  parameter int               PC_REG     = 15,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic             mem_op,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic             alu_src,
  input  logic             branch,
  input  logic             cond_pass,
  input  logic [1:0]       imm_src,
  input  logic [1:0]       reg_src,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       alu_flags,
  output logic             retire
);

  localparam logic [REG_ADDR_W-1:0] PC_IDX =
    REG_ADDR_W'(PC_REG);

  mc_state_t state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [WIDTH-1:0] mdr_q;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       nzcv;
  logic [WIDTH-1:0] wb_data;
  logic             is_sub;
  logic             alu_c;
  logic             alu_v;
  logic             rf_we;

  logic [REG_ADDR_W-1:0] rn;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rm;
  logic [REG_ADDR_W-1:0] ra1;
  logic [REG_ADDR_W-1:0] ra2;

  assign rn = instr[16 +: REG_ADDR_W];
  assign rd = instr[12 +: REG_ADDR_W];
  assign rm = instr[0 +: REG_ADDR_W];

  assign ra1 = reg_src[RS_PC_A] ? PC_IDX : rn;
  assign ra2 = reg_src[RS_RD_B] ? rd : rm;

  // pc is already past the fetch, so this is fetch+8 in DECODE
  assign pc_plus4 = pc + WIDTH'(PC_INC);

  assign wb_data = mem_to_reg ? mdr_q : alu_out_q;
  assign rf_we   = (state == WRITEBACK) & reg_write
                 & (rd != PC_IDX);

  mc_register_file #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W),
    .PC_REG     (PC_REG)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (rf_we),
    .ra1 (ra1),
    .ra2 (ra2),
    .wa  (rd),
    .wd  (wb_data),
    .r15 (pc_plus4),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // immediate extend
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_ZX8:  imm_ext = WIDTH'(instr[7:0]);
      IMM_ZX12: imm_ext = WIDTH'(instr[11:0]);
      IMM_BR24: imm_ext =
        WIDTH'($signed({instr[23:0], 2'b00}));
      default:  imm_ext = '0;
    endcase
  end

  assign src_b  = alu_src ? imm_ext : b_q;
  assign is_sub = (alu_control == ALU_SUB);
  assign b_eff  = is_sub ? ~src_b : src_b;
  assign sum    = {1'b0, a_q} + {1'b0, b_eff}
                + (WIDTH + 1)'(is_sub);

  // ALU result and carry/overflow
  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    alu_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1])
            & (sum[WIDTH-1] != a_q[WIDTH-1]);
    case (alu_control)
      ALU_AND: begin
        alu_res = a_q & src_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      ALU_ORR: begin
        alu_res = a_q | src_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      ALU_EOR: begin
        alu_res = a_q ^ src_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      ALU_MOV: begin
        alu_res = src_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      default: ;
    endcase
  end

  assign nzcv = {alu_res[WIDTH-1], alu_res == '0,
                 alu_c, alu_v};

  // sequencer and inter-state latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      alu_flags <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            instr <= 32'(mem_rdata);
            pc    <= pc_plus4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= rd1;
          b_q   <= rd2;
          state <= EXECUTE;
        end
        EXECUTE: begin
          if (!cond_pass) begin
            state <= FETCH;
          end else begin
            alu_out_q <= alu_res;
            alu_flags <= nzcv;
            if (branch) begin
              pc    <= alu_res;
              state <= FETCH;
            end else if (mem_op) begin
              state <= MEMORY;
            end else begin
              state <= WRITEBACK;
            end
          end
        end
        MEMORY: begin
          if (mem_ready) begin
            if (mem_write) begin
              state <= FETCH;
            end else begin
              mdr_q <= mem_rdata;
              state <= WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          if (reg_write && rd == PC_IDX)
            pc <= wb_data;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // request is dropped while reset is held
  assign mem_req = ~rst & ((state == FETCH)
                 | (state == MEMORY));
  assign mem_we  = ~rst & (state == MEMORY) & mem_write;
  assign mem_addr  = (state == MEMORY) ? alu_out_q : pc;
  assign mem_wdata = b_q;

  assign retire = (state == WRITEBACK)
    | ((state == EXECUTE) & (~cond_pass | branch))
    | ((state == MEMORY) & mem_ready & mem_write);

endmodule

// File: tb/tb_multi_cycle_data_path.sv
// tb_multi_cycle_data_path: directed instruction sequence
// with a tiny memory responder and hand-computed results.
module tb_multi_cycle_data_path;

  typedef struct packed {
    logic       reg_write;
    logic       mem_op;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       cond_pass;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] alu_control;
  } ctl_t;

  logic        clk;
  logic        rst;
  ctl_t        ctl;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [3:0]  alu_flags;
  logic        retire;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          dreq;
  logic [31:0] faddr;
  logic [31:0] daddr;
  logic        dwe;
  logic [31:0] dwd;

  multi_cycle_data_path dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write   (ctl.reg_write),
    .mem_op      (ctl.mem_op),
    .mem_write   (ctl.mem_write),
    .mem_to_reg  (ctl.mem_to_reg),
    .alu_src     (ctl.alu_src),
    .branch      (ctl.branch),
    .cond_pass   (ctl.cond_pass),
    .imm_src     (ctl.imm_src),
    .reg_src     (ctl.reg_src),
    .alu_control (ctl.alu_control),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .instr       (instr),
    .pc          (pc),
    .alu_flags   (alu_flags),
    .retire      (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t mk(
    input logic rw, input logic mo, input logic mw,
    input logic m2r, input logic as, input logic br,
    input logic cp, input logic [1:0] is,
    input logic [1:0] rs, input logic [3:0] op);
    ctl_t c;
    c.reg_write   = rw;
    c.mem_op      = mo;
    c.mem_write   = mw;
    c.mem_to_reg  = m2r;
    c.alu_src     = as;
    c.branch      = br;
    c.cond_pass   = cp;
    c.imm_src     = is;
    c.reg_src     = rs;
    c.alu_control = op;
    return c;
  endfunction

  ctl_t c_addi, c_addr, c_subi, c_str, c_ldr;
  ctl_t c_b, c_bnt, c_addpc, c_movpc;

  // one instruction, zero-wait fetch, dwait wait states on data
  task automatic run(
    input  logic [31:0] iw, input ctl_t c,
    input  logic [31:0] rdat, input int dwait);
    bit fetched;
    bit done;
    ctl = c;
    cyc = 0;
    dreq = 0;
    fetched = 0;
    done = 0;
    faddr = 32'hFFFF_FFFF;
    daddr = 32'hFFFF_FFFF;
    dwe = 1'b0;
    dwd = 32'h0;
    while (!done && cyc < 20) begin
      #1;
      mem_ready = 1'b0;
      if (mem_req && !fetched) begin
        faddr = mem_addr;
        mem_rdata = iw;
        mem_ready = 1'b1;
        fetched = 1;
      end else if (mem_req) begin
        dreq++;
        daddr = mem_addr;
        dwe = mem_we;
        dwd = mem_wdata;
        if (dreq > dwait) begin
          mem_rdata = rdat;
          mem_ready = 1'b1;
        end
      end
      #1;
      if (retire) done = 1;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL run_retire got timeout want retire for %h", iw);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ctl = '0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", mem_req); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", mem_we); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", pc); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr); end
    n_vec++; if (alu_flags !== 4'h0) begin n_err++; $display("FAIL rst_flags got %h want 0", alu_flags); end
    n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL rst_retire got %b want 0", retire); end
    rst = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rel_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rel_addr got %h want 0", mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_data_processing;
    run(32'hE2802005, c_addi, 32'h0, 0);
    n_vec++; if (faddr !== 32'h0) begin n_err++; $display("FAIL addi_faddr got %h want 0", faddr); end
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL addi_cycles got %0d want 4", cyc); end
    n_vec++; if (pc !== 32'h4) begin n_err++; $display("FAIL addi_pc got %h want 4", pc); end
    run(32'hE2803007, c_addi, 32'h0, 0);
    n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL addi2_pc got %h want 8", pc); end
    run(32'hE0821003, c_addr, 32'h0, 0);
    n_vec++; if (faddr !== 32'h8) begin n_err++; $display("FAIL add_faddr got %h want 8", faddr); end
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL add_cycles got %0d want 4", cyc); end
    n_vec++; if (pc !== 32'hC) begin n_err++; $display("FAIL add_pc got %h want c", pc); end
    n_vec++; if (alu_flags !== 4'b0000) begin n_err++; $display("FAIL add_flags got %b want 0000", alu_flags); end
    #1;
    n_vec++; if (retire !== 1'b0) begin n_err++; $display("FAIL add_retire_once got %b want 0", retire); end
    n_vec++; if (mem_addr !== 32'hC) begin n_err++; $display("FAIL add_next_fetch got %h want c", mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_store;
    run(32'hE5801010, c_str, 32'h0, 0);
    n_vec++; if (daddr !== 32'h10) begin n_err++; $display("FAIL str_addr got %h want 10", daddr); end
    n_vec++; if (dwe !== 1'b1) begin n_err++; $display("FAIL str_we got %b want 1", dwe); end
    n_vec++; if (dwd !== 32'hC) begin n_err++; $display("FAIL str_wdata got %h want c", dwd); end
    n_vec++; if (dreq !== 1) begin n_err++; $display("FAIL str_memcycles got %0d want 1", dreq); end
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL str_cycles got %0d want 4", cyc); end
    n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL str_pc got %h want 10", pc); end
  endtask

  task automatic test_load_wait;
    run(32'hE5904008, c_ldr, 32'hDEADBEEF, 2);
    n_vec++; if (daddr !== 32'h8) begin n_err++; $display("FAIL ldr_addr got %h want 8", daddr); end
    n_vec++; if (dwe !== 1'b0) begin n_err++; $display("FAIL ldr_we got %b want 0", dwe); end
    n_vec++; if (dreq !== 3) begin n_err++; $display("FAIL ldr_reqcycles got %0d want 3", dreq); end
    n_vec++; if (cyc !== 7) begin n_err++; $display("FAIL ldr_cycles got %0d want 7", cyc); end
    n_vec++; if (pc !== 32'h14) begin n_err++; $display("FAIL ldr_pc got %h want 14", pc); end
    run(32'hE5804020, c_str, 32'h0, 0);
    n_vec++; if (dwd !== 32'hDEADBEEF) begin n_err++; $display("FAIL ldr_r4 got %h want deadbeef", dwd); end
    n_vec++; if (daddr !== 32'h20) begin n_err++; $display("FAIL str4_addr got %h want 20", daddr); end
  endtask

  task automatic test_flags;
    run(32'hE2505001, c_subi, 32'h0, 0);
    n_vec++; if (alu_flags !== 4'b1000) begin n_err++; $display("FAIL sub_flags got %b want 1000", alu_flags); end
    run(32'hE2856001, c_addi, 32'h0, 0);
    n_vec++; if (alu_flags !== 4'b0110) begin n_err++; $display("FAIL wrap_flags got %b want 0110", alu_flags); end
    n_vec++; if (pc !== 32'h20) begin n_err++; $display("FAIL flags_pc got %h want 20", pc); end
  endtask

  task automatic test_branch;
    run(32'hEA000002, c_b, 32'h0, 0);
    n_vec++; if (faddr !== 32'h20) begin n_err++; $display("FAIL b_faddr got %h want 20", faddr); end
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL b_cycles got %0d want 3", cyc); end
    n_vec++; if (pc !== 32'h30) begin n_err++; $display("FAIL b_pc got %h want 30", pc); end
    n_vec++; if (alu_flags !== 4'b0000) begin n_err++; $display("FAIL b_flags got %b want 0000", alu_flags); end
    run(32'hE2505001, c_subi, 32'h0, 0);
    n_vec++; if (faddr !== 32'h30) begin n_err++; $display("FAIL b_target_fetch got %h want 30", faddr); end
    run(32'hEA000002, c_bnt, 32'h0, 0);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL bnt_cycles got %0d want 3", cyc); end
    n_vec++; if (pc !== 32'h38) begin n_err++; $display("FAIL bnt_pc got %h want 38", pc); end
    n_vec++; if (alu_flags !== 4'b1000) begin n_err++; $display("FAIL bnt_flags got %b want 1000", alu_flags); end
  endtask

  task automatic test_pc_operand;
    run(32'hE28F7000, c_addpc, 32'h0, 0);
    run(32'hE5807000, c_str, 32'h0, 0);
    n_vec++; if (dwd !== 32'h40) begin n_err++; $display("FAIL pcop_r7 got %h want 40", dwd); end
    n_vec++; if (daddr !== 32'h0) begin n_err++; $display("FAIL pcop_addr got %h want 0", daddr); end
    n_vec++; if (pc !== 32'h40) begin n_err++; $display("FAIL pcop_pc got %h want 40", pc); end
  endtask

  task automatic test_pc_write;
    run(32'hE3A0F100, c_movpc, 32'h0, 0);
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL movpc_cycles got %0d want 4", cyc); end
    n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL movpc_pc got %h want 100", pc); end
    run(32'hE5801004, c_str, 32'h0, 0);
    n_vec++; if (faddr !== 32'h100) begin n_err++; $display("FAIL movpc_fetch got %h want 100", faddr); end
    n_vec++; if (dwd !== 32'hC) begin n_err++; $display("FAIL movpc_r1 got %h want c", dwd); end
  endtask

  task automatic test_reset_mid_memory;
    ctl = c_ldr;
    #1;
    mem_rdata = 32'hE5904008;
    mem_ready = mem_req;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h8) begin n_err++; $display("FAIL mid_addr got %h want 8", mem_addr); end
    rst = 1'b1;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got %b want 0", mem_req); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_pc got %h want 0", pc); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL mid_rst_instr got %h want 0", instr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_rel_req got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL mid_rel_addr got %h want 0", mem_addr); end
    @(negedge clk);
    run(32'hE5801000, c_str, 32'h0, 0);
    n_vec++; if (faddr !== 32'h0) begin n_err++; $display("FAIL post_rst_fetch got %h want 0", faddr); end
    n_vec++; if (dwd !== 32'h0) begin n_err++; $display("FAIL post_rst_r1 got %h want 0", dwd); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    c_addi  = mk(1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 4'h0);
    c_addr  = mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'h0);
    c_subi  = mk(1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 4'h1);
    c_str   = mk(0, 1, 1, 0, 1, 0, 1, 2'b01, 2'b10, 4'h0);
    c_ldr   = mk(1, 1, 0, 1, 1, 0, 1, 2'b01, 2'b00, 4'h0);
    c_b     = mk(0, 0, 0, 0, 1, 1, 1, 2'b10, 2'b01, 4'h0);
    c_bnt   = mk(0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b01, 4'h0);
    c_addpc = mk(1, 0, 0, 0, 1, 0, 1, 2'b00, 2'b01, 4'h0);
    c_movpc = mk(1, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 4'h5);
    test_reset();
    test_data_processing();
    test_store();
    test_load_wait();
    test_flags();
    test_branch();
    test_pc_operand();
    test_pc_write();
    test_reset_mid_memory();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_cycle_data_path.md
Name: multi_cycle_data_path

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath. It executes one instruction over 3–5 cycles through a single shared instruction/data memory port with a req/ready handshake.
- An internal sequencer FSM steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and latches IR, A, B, ALU_OUT and MDR between states.
- The external combinational decoder reads `instr` and drives the control inputs. The existing `ALU`, `extend`, `adder` and `mux_2_x_1` blocks are reused.

Parameters:
- WIDTH, 32, datapath/register/address width.
- REG_ADDR_W, 4, register index width (2**REG_ADDR_W registers).
- PC_REG, 15, register index aliased to PC.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- reg_write  in  1  instruction writes Rd at WRITEBACK
- mem_op  in  1  instruction is a load or store
- mem_write  in  1  store (valid when mem_op=1)
- mem_to_reg  in  1  WRITEBACK source: 1=MDR, 0=ALU_OUT
- alu_src  in  1  ALU B operand: 1=imm_ext, 0=B latch
- branch  in  1  instruction writes PC with ALU result
- cond_pass  in  1  condition check passed (sampled in EXECUTE)
- imm_src  in  2  extend mode
- reg_src  in  2  register address select, same encoding as the single-cycle datapath
- alu_control  in  4  ALU op
- mem_rdata  in  WIDTH  memory read data
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualifies mem_req
- mem_addr  out  WIDTH  request address
- mem_wdata  out  WIDTH  store data
- instr  out  32  instruction register
- pc  out  WIDTH  program counter
- alu_flags  out  4  NZCV, registered in EXECUTE when cond_pass=1
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC; state=FETCH; instr=0; alu_flags=0; mem_req=0; mem_we=0; retire=0.
  - Register file cleared to 0.
  - An outstanding memory request is abandoned; the memory must tolerate this.
- FETCH:
  - Drives mem_req=1, mem_we=0, mem_addr=pc, held until mem_ready=1.
  - On the ready cycle: instr<=mem_rdata, pc<=pc+4, go to DECODE.
  - mem_ready in the same cycle as the request counts as a 1-cycle access. mem_ready while mem_req=0 is ignored.
- DECODE:
  - A<=rd1, B<=rd2. Addresses come from instr via reg_src, as in the single-cycle datapath.
  - A read of PC_REG returns pc+4, i.e. fetch address + 8.
  - Control inputs must be stable from DECODE until the instruction retires.
- EXECUTE: ALU_OUT<=ALU(A, alu_src ? imm_ext : B).
  - cond_pass=0: no state change, retire=1, go to FETCH.
  - branch=1: pc<=ALU result, retire=1, go to FETCH.
  - mem_op=1: go to MEMORY.
  - Otherwise: go to WRITEBACK.
  - Flags update only when cond_pass=1.
- MEMORY:
  - mem_req=1, mem_addr=ALU_OUT, mem_we=mem_write, mem_wdata=B, all held until mem_ready.
  - Store: on ready, retire=1, go to FETCH.
  - Load: on ready, MDR<=mem_rdata, go to WRITEBACK.
- WRITEBACK:
  - If reg_write: rf[Rd]<=(mem_to_reg ? MDR : ALU_OUT).
  - If Rd==PC_REG: pc is written with the same value and the register-file write is suppressed.
  - retire=1, go to FETCH.
- Latency with zero-wait memory:
  - Data-processing: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or failed condition: 3 cycles.
  - Each memory wait cycle adds one.
- Arithmetic: all adders and the ALU are WIDTH bits, wrap modulo 2**WIDTH. pc=2**WIDTH-4 wraps to 0.
- No other state is entered. Unused state encodings go to FETCH.

Decomposition:
- Package multi_cycle_pkg holds:
  - typedef enum mc_state_t {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK}
  - localparams for the reg_src/imm_src encodings
  - the PC increment constant
- One new sub-module, mc_register_file, parametrised on WIDTH and REG_ADDR_W:
  - two combinational read ports, one synchronous write port
  - PC_REG read returns the r15 input
  - asynchronous clear
- The sequencer FSM stays inline in multi_cycle_data_path.

Test Plan:
- Reset, then zero-wait memory with an ADD R1,R2,R3 encoding (R2=5, R3=7) at address 0 -> mem_addr=0 at cycle 0; R1=12 after 4 cycles; retire pulses once; pc=4.
- Load LDR R4,[R0,#8] with mem_rdata=0xDEADBEEF and 2 wait states on the data access -> mem_addr=8, mem_req held 3 cycles; R4=0xDEADBEEF; 7 cycles total.
- Store STR R1,[R0,#16] with R1=0x55 -> one MEMORY cycle with mem_we=1, mem_addr=16, mem_wdata=0x55; no register changes.
- Branch at pc=0x20 with offset +8 (ALU result 0x30), cond_pass=1 -> pc=0x30 after 3 cycles; next fetch mem_addr=0x30. Repeat with cond_pass=0 -> pc=0x24 and alu_flags unchanged.
- ADD using R15 as operand at pc=0x40 plus #0 -> result 0x48. MOV into PC_REG=0x100 -> pc=0x100, register file unchanged.
- Assert rst mid-MEMORY with mem_req high -> mem_req=0 immediately; pc=RESET_PC; state FETCH; the next cycle after reset release requests address 0.
